mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Sequencer that sits directly upstream and downstream of the 4:1 bit multiplexer (mux4_1). It drives the multiplexer's `s1:s0` select lines through channels 0–3 and samples the multiplexer output once per channel. It then presents the four sampled bits as a single 4-bit word under a valid/ready handshake. It turns the combinational mux into a scanned 4-channel bit capture stage.

## Interface
- `DWELL`, default 1: cycles the select is held per channel before sampling; legal range 1..16.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a scan; sampled only in IDLE.
- `mux_out`  in  1  output of the 4:1 mux, driven from `s1`/`s0`.
- `s0`  out  1  select bit 0 to the mux (channel index bit 0).
- `s1`  out  1  select bit 1 to the mux (channel index bit 1).
- `word`  out  4  captured word; `word[i]` = mux output while channel i was selected.
- `valid`  out  1  `word` is complete and stable.
- `ready`  in  1  consumer accepts `word` when `valid && ready`.
- `busy`  out  1  high in SCAN and HOLD.

## Operation
- Reset (`rst_n`=0 at an edge): state=IDLE, sel=0, dwell count=0, `word`=0, `valid`=0, `busy`=0. This applies from any state, including mid-scan or mid-HOLD; any partial word is discarded.
- `{s1,s0}` equals the channel register `sel[1:0]` at all times, and is registered. It is 00 in IDLE and HOLD.
- IDLE:
  - If `start`=1: go to SCAN, with sel=0, cnt=0 and `word` cleared to 0.
  - Otherwise stay in IDLE.
- SCAN:
  - Each cycle, if cnt < `DWELL`-1, then cnt++.
  - When cnt == `DWELL`-1: `word[sel]` <= `mux_out`, and cnt <= 0.
    - If sel < 3, then sel++.
    - If sel == 3, go to HOLD with `valid`=1 and sel=0.
  - `start` is ignored in SCAN.
- HOLD:
  - `valid`=1, and `word` is frozen.
  - When `valid && ready` at an edge, go to IDLE and set `valid`=0.
  - `start` is ignored in HOLD; a new scan needs `start` seen in IDLE, at least one cycle after the handshake.
- Width rules:
  - cnt is 4 bits and compares against `DWELL`-1, so no overflow for `DWELL` ≤ 16.
  - sel is 2 bits and never wraps inside SCAN; the exit at 3 is explicit.
- The mux path is combinational. `mux_out` therefore reflects channel `sel` in the same cycle the select is driven, and the sample is taken on the last dwell cycle.

## Timing
- Let E0 be the edge where `start` is captured in IDLE.
  - Channel i is selected for edges E0+i·`DWELL` through E0+(i+1)·`DWELL`.
  - `word[i]` is captured at edge E0+(i+1)·`DWELL`.
- `valid` rises at edge E0+4·`DWELL`.
  - With `DWELL`=1, that is 4 cycles after the start capture.
- Earliest `valid` fall is one edge after it rises, with `ready` already high.
- `ready` high before `valid` is permitted; the transfer completes on the first edge where both are high.
- `busy` rises at E0 and falls on the handshake edge.
- Back-to-back scans: IDLE lasts at least 1 cycle between words. Throughput is one word per 4·`DWELL`+2 cycles.
- Reset asserted coincident with a handshake or a sample edge wins: no capture, and all outputs go to reset values.

## Structure
- Shared package `mux_scan_pkg` holds:
  - State encodings: IDLE=2'b00, SCAN=2'b01, HOLD=2'b10. 2'b11 is illegal and recovers to IDLE.
  - Constants `NUM_CH`=4, `SEL_W`=2, `CNT_W`=4.
- One sub-module, `dwell_timer`:
  - Parameterised by `DWELL`.
  - Inputs: `clk`, `rst_n`, `clear`, `en`.
  - Output: `tick`, high on the last dwell cycle.
  - It owns cnt. The FSM, `sel`, `word` and the handshake stay in `mux_scan_ctrl`.
- Integration top: instantiates `mux_scan_ctrl` with mux4_1, wiring `s0`/`s1` to the mux and the mux `out` to `mux_out`.

## Test plan
- Reset, then hold `start`=0 for 10 cycles -> `{s1,s0}`=00, `word`=0, `valid`=0, `busy`=0 throughout.
- `DWELL`=1, mux inputs d0..d3 = 1,1,0,1, pulse `start`, `ready`=1 -> `{s1,s0}` steps 00,01,10,11. `valid` rises 4 edges after start capture with `word`=4'b1011. `valid` drops next edge, and `busy` falls.
- `DWELL`=3, d0..d3 = 0,1,1,0, `ready`=0 -> each select is held 3 cycles. `valid` rises at E0+12 with `word`=4'b0110. The word stays frozen while `ready` is low for 20 cycles, then the handshake completes on the first `ready` edge.
- Pulse `start` again mid-SCAN and while in HOLD -> no restart. Sequence timing is unchanged and the word is unchanged.
- Assert `rst_n`=0 for one edge after channel 1 is sampled -> next cycle: IDLE, `word`=0, `valid`=0, `{s1,s0}`=00. A subsequent `start` yields a correct full word.
- Toggle d1 during channel 1's dwell with `DWELL`=2 -> `word[1]` equals the value present on the last dwell cycle only.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared constants for the scanned 4:1 mux capture stage.
//   State encodings for the scan FSM and the widths of the channel index
//   and dwell counter.
package mux_scan_pkg;

  // FSM state encodings; 2'b11 is unused and recovers to StIdle.
  localparam logic [1:0] StIdle = 2'b00;
  localparam logic [1:0] StScan = 2'b01;
  localparam logic [1:0] StHold = 2'b10;

  localparam int unsigned NUM_CH = 4;  // mux channels scanned per word
  localparam int unsigned SEL_W  = 2;  // channel index width
  localparam int unsigned CNT_W  = 4;  // dwell counter width (DWELL <= 16)

endpackage

// File: rtl/mux_scan_ctrl_dwell_timer.sv
// dwell_timer: counts the cycles a channel select is held.
//   i_clk   : system clock
//   i_rst_n : synchronous active-low reset
//   i_clear : force the count back to 0
//   i_en    : advance the count this cycle
//   o_tick  : high on the last dwell cycle (count == DWELL-1 while enabled)
module dwell_timer
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DWELL - 1));
  assign o_tick = i_en & w_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      // Wrap on the last dwell cycle so the next channel starts at 0.
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 4:1 mux select through channels 0..3, samples the
// mux output on the last dwell cycle of each channel and presents the four
// bits as one word under a valid/ready handshake.
//   i_clk     : system clock
//   i_rst_n   : synchronous active-low reset
//   i_start   : scan request, honoured only in idle
//   i_mux_out : combinational mux output for the current select
//   o_s0/o_s1 : registered select lines to the mux
//   o_word    : captured word, o_word[i] sampled while channel i selected
//   o_valid   : o_word complete and stable
//   i_ready   : consumer accepts o_word when o_valid && i_ready
//   o_busy    : scan or hold in progress
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mux_out,
  output logic              o_s0,
  output logic              o_s1,
  output logic [NUM_CH-1:0] o_word,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy
);

  logic [1:0]        r_state;
  logic [SEL_W-1:0]  r_sel;
  logic [NUM_CH-1:0] r_word;
  logic              r_valid;

  logic w_tick;
  logic w_scan;

  assign w_scan = (r_state == StScan);

  // Timer only runs in scan; held at 0 otherwise so every scan starts fresh.
  dwell_timer #(
    .DWELL(DWELL)
  ) u_dwell_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clear(~w_scan),
    .i_en   (w_scan),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_sel   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_state <= StScan;
            r_sel   <= '0;
            r_word  <= '0;
          end
        end
        StScan: begin
          if (w_tick) begin
            r_word[r_sel] <= i_mux_out;
            // Explicit exit at the last channel; sel never wraps in scan.
            if (r_sel == SEL_W'(NUM_CH - 1)) begin
              r_state <= StHold;
              r_valid <= 1'b1;
              r_sel   <= '0;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
          end
        end
        StHold: begin
          if (r_valid && i_ready) begin
            r_state <= StIdle;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_sel   <= '0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_s0    = r_sel[0];
  assign o_s1    = r_sel[1];
  assign o_word  = r_word;
  assign o_valid = r_valid;
  assign o_busy  = (r_state == StScan) || (r_state == StHold);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl. Three instances (DWELL = 1, 3, 2) each
// drive a behavioural 4:1 mux built from a per-instance d[3:0] vector.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [3];
  logic       start   [3];
  logic       ready   [3];
  logic [3:0] d       [3];
  logic       mux_out [3];
  logic       s0      [3];
  logic       s1      [3];
  logic       valid   [3];
  logic       busy    [3];
  logic [3:0] word    [3];

  int n_cmp = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    assign mux_out[g] = d[g][{s1[g], s0[g]}];
    mux_scan_ctrl #(
      .DWELL(DW)
    ) u_dut (
      .i_clk    (clk),
      .i_rst_n  (rst_n[g]),
      .i_start  (start[g]),
      .i_mux_out(mux_out[g]),
      .o_s0     (s0[g]),
      .o_s1     (s1[g]),
      .o_word   (word[g]),
      .o_valid  (valid[g]),
      .i_ready  (ready[g]),
      .o_busy   (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] sel_of(input int i);
    return {s1[i], s0[i]};
  endfunction

  task automatic idle_chk(input int i, input string tag);
    check({tag, "_sel"}, 32'(sel_of(i)), 32'd0);
    check({tag, "_word"}, 32'(word[i]), 32'd0);
    check({tag, "_valid"}, 32'(valid[i]), 32'd0);
    check({tag, "_busy"}, 32'(busy[i]), 32'd0);
  endtask

  // DWELL=2 scan with d1 changed between the two dwell cycles of channel 1.
  task automatic scan_d2(input logic d1_first, input logic d1_last, input logic [3:0] exp);
    d[2] = 4'b0101;
    ready[2] = 1'b1;
    start[2] = 1'b1;
    step();  // E0
    start[2] = 1'b0;
    step();  // E0+1
    step();  // E0+2: channel 1 selected
    check("d2_sel_e2", 32'(sel_of(2)), 32'd1);
    d[2][1] = d1_first;
    step();  // E0+3: second dwell cycle of channel 1
    check("d2_sel_e3", 32'(sel_of(2)), 32'd1);
    d[2][1] = d1_last;
    step();  // E0+4: channel 1 sampled
    check("d2_sel_e4", 32'(sel_of(2)), 32'd2);
    step();
    step();  // E0+6
    check("d2_sel_e6", 32'(sel_of(2)), 32'd3);
    step();
    step();  // E0+8
    check("d2_valid", 32'(valid[2]), 32'd1);
    check("d2_word", 32'(word[2]), 32'(exp));
    step();  // handshake
    check("d2_valid_fall", 32'(valid[2]), 32'd0);
    check("d2_busy_fall", 32'(busy[2]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      ready[i] = 1'b0;
      d[i]     = 4'b0000;
    end
    step();
    step();
    for (int i = 0; i < 3; i++) idle_chk(i, "reset");
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // Idle with start low.
    for (int k = 0; k < 10; k++) begin
      step();
      idle_chk(0, "idle");
    end

    // DWELL=1 scan, ready already high.
    d[0] = 4'b1011;
    ready[0] = 1'b1;
    start[0] = 1'b1;
    step();  // E0
    start[0] = 1'b0;
    check("d1_sel_e0", 32'(sel_of(0)), 32'd0);
    check("d1_busy_e0", 32'(busy[0]), 32'd1);
    check("d1_valid_e0", 32'(valid[0]), 32'd0);
    for (int k = 1; k < 4; k++) begin
      step();
      check("d1_sel_step", 32'(sel_of(0)), 32'(k));
      check("d1_valid_early", 32'(valid[0]), 32'd0);
    end
    step();  // E0+4
    check("d1_valid_rise", 32'(valid[0]), 32'd1);
    check("d1_word", 32'(word[0]), 32'hb);
    check("d1_sel_hold", 32'(sel_of(0)), 32'd0);
    check("d1_busy_hold", 32'(busy[0]), 32'd1);
    step();  // E0+5 handshake
    check("d1_valid_fall", 32'(valid[0]), 32'd0);
    check("d1_busy_fall", 32'(busy[0]), 32'd0);
    check("d1_word_kept", 32'(word[0]), 32'hb);

    // DWELL=3 scan, ready low, stray starts in scan and hold.
    d[1] = 4'b0110;
    ready[1] = 1'b0;
    start[1] = 1'b1;
    step();  // E0
    for (int k = 1; k <= 32; k++) begin
      start[1] = (k == 5 || k == 14);
      step();
      check("d3_sel", 32'(sel_of(1)), (k < 12) ? 32'(k / 3) : 32'd0);
      check("d3_valid", 32'(valid[1]), (k >= 12) ? 32'd1 : 32'd0);
      check("d3_busy", 32'(busy[1]), 32'd1);
      if (k >= 12) check("d3_word", 32'(word[1]), 32'h6);
    end
    start[1] = 1'b0;
    ready[1] = 1'b1;
    step();
    check("d3_valid_fall", 32'(valid[1]), 32'd0);
    check("d3_busy_fall", 32'(busy[1]), 32'd0);
    step();
    check("d3_no_restart", 32'(busy[1]), 32'd0);
    ready[1] = 1'b0;

    // Reset after channel 1 sampled, then a clean rescan.
    d[0] = 4'b1111;
    ready[0] = 1'b0;
    start[0] = 1'b1;
    step();  // E0
    start[0] = 1'b0;
    step();  // ch0 sampled
    step();  // ch1 sampled
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    idle_chk(0, "rst_mid");
    d[0] = 4'b0101;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    repeat (4) step();
    check("rescan_valid", 32'(valid[0]), 32'd1);
    check("rescan_word", 32'(word[0]), 32'h5);
    // Reset coincident with the handshake edge wins.
    ready[0] = 1'b1;
    rst_n[0] = 1'b0;
    step();
    rst_n[0] = 1'b1;
    ready[0] = 1'b0;
    idle_chk(0, "rst_hs");

    // DWELL=2: only the last dwell cycle of channel 1 counts.
    scan_d2(1'b1, 1'b0, 4'b0101);
    scan_d2(1'b0, 1'b1, 4'b0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
